mw_expander: RTL and testbench
==============================

# mw_expander

Sequential instruction expander between fetch and decode. It converts each load/store-multiple word instruction (LMW, STMW) into a stream of equivalent single-word D-form instructions (LWZ, STW), one per register, so the decode/cluster logic and the LSU handle only single-word accesses. All other instructions pass through unchanged with one register stage. Both sides use a valid/ready handshake.

## Interface
- INSTR_WIDTH, 32: instruction word width; bit 0 is MSB.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  upstream instruction valid.
- in_instr  in  [0:INSTR_WIDTH-1]  instruction word.
- in_ready  out  1  input accepted when in_valid && in_ready.
- out_valid  out  1  out_instr valid.
- out_instr  out  [0:INSTR_WIDTH-1]  emitted instruction.
- out_last  out  1  final word of the current input instruction.
- out_raw  out  1  LMW/STMW passed unexpanded; downstream must trap it as an illegal form.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- busy  out  1  expansion in progress (state EXPAND).

## Operation
- Fields: OPCD [0:5], RT/RS [6:10], RA [11:15], D [16:31] (signed). Opcodes: LMW=46, STMW=47, LWZ=32, STW=36.
- Output register: out_instr, out_last, out_raw, out_valid. It loads when it is empty or being consumed (out_ready).
- FSM states:
  - IDLE:
    - in_ready = !out_valid || out_ready.
    - On accept, expandable LMW/STMW: load word k=0. Go to EXPAND with reg=RT+1, unless RT=31, in which case set out_last=1 and stay in IDLE.
    - On accept, any other instruction: load it verbatim with out_last=1, out_raw=0.
  - EXPAND:
    - in_ready=0.
    - On each output consume, load the next word for reg.
    - When reg=31, set out_last=1 and return to IDLE.
- Word k, for reg=RT+k:
  - Opcode becomes LWZ (for LMW) or STW (for STMW).
  - Register field = reg.
  - RA is unchanged.
  - D' = D + 4k.
- Displacement arithmetic: computed in 17-bit signed, result truncated to 16 bits. Only legal forms reach this path, so no overflow occurs.
- Non-expandable forms pass verbatim with out_raw=1, out_last=1:
  - LMW with RA≠0 and RA≥RT (the base register would be overwritten mid-sequence).
  - D + 4·(31−RT) > 32767 (a per-word displacement is not representable).
- The latched base fields (RA, D, RT, opcode) are held in state registers for the whole expansion. in_instr may change after acceptance.
- flush:
  - Clears out_valid, out_last and out_raw, and forces IDLE. Any remaining expansion is discarded.
  - flush has priority over a simultaneous accept; in_ready is 0 while flush=1.
- Reset mid-expansion discards the sequence and takes the reset values below.

## Timing
- Reset values: out_valid=0, out_instr=0, out_last=0, out_raw=0, busy=0. in_ready=1 after reset (combinational).
- Latency: accept at edge N → out_valid=1 after edge N.
- Throughput: one word per cycle under continuous out_ready. An LMW/STMW of RT occupies 32−RT cycles.
- A new instruction is accepted in the same cycle the last word is consumed, giving back-to-back streams with no bubble.
- Backpressure: while out_valid && !out_ready, out_instr, out_last and out_raw hold stable and the FSM does not advance.
- in_ready and busy are combinational from state and out_ready. There is no combinational path from in_valid to out_*.

## Configuration
- STMW_EXPAND_EN:
  - Defined: both LMW and STMW are expanded.
  - Undefined: only LMW is expanded. Every STMW passes verbatim with out_raw=1, out_last=1, and the STMW opcode-select logic is removed.

## Structure
- Opcode constants (LMW, STMW, LWZ, STW) and field bit ranges belong in the shared instruction definition header. Nothing is defined locally.
- One sub-module: mw_form_check (combinational).
  - Inputs: opcode, RT, RA, D.
  - Outputs: is_mw, expandable.
- The FSM, counter and output register stay in mw_expander.

## Test plan
- LMW r29,8(r1) = 0xBBA10008, out_ready=1 → 0x83A10008, 0x83C1000C, 0x83E10010 on consecutive cycles; out_last on the third word only; in_ready=0 for two cycles.
- STMW r30,-8(r1) = 0xBFC1FFF8 → 0x93C1FFF8, 0x93E1FFFC with out_last on the second. Without STMW_EXPAND_EN → 0xBFC1FFF8 with out_raw=1.
- ADDI 0x38600001 followed by LMW r31,0(r1) (0xBBE10000) → 0x38600001 then 0x83E10000, each with out_last=1, no bubble.
- Illegal forms → passed verbatim with out_raw=1 and out_last=1:
  - LMW r28,0(r30) = 0xBB9E0000.
  - LMW r0,0x7FF0(r1) = 0xB8017FF0.
- Backpressure, flush and reset during LMW r29:
  - Drop out_ready for 3 cycles on word 2 → out_instr holds 0x83C1000C; the sequence completes afterwards.
  - Flush during the sequence → next cycle out_valid=0, busy=0, in_ready=1.
  - rst_n low mid-sequence → all outputs at their reset values.

Source files
------------

// File: rtl/mw_expander_pkg.sv
// Shared instruction definitions for the load/store-multiple expander:
// opcode constants, field bit ranges (bit 0 is the MSB of the word),
// FSM state type and helpers used to assemble expanded D-form words.
// Optional feature macro: STMW_EXPAND_EN (see mw_form_check / mw_expander).
package mw_expander_pkg;

    // Instruction word width the field layout below is defined for
    localparam int INSTR_W = 32;

    // Field bit ranges, big-endian numbering (bit 0 = MSB)
    localparam int OPCD_HI = 0;
    localparam int OPCD_LO = 5;
    localparam int RT_HI   = 6;
    localparam int RT_LO   = 10;
    localparam int RA_HI   = 11;
    localparam int RA_LO   = 15;
    localparam int D_HI    = 16;
    localparam int D_LO    = 31;

    // Primary opcodes
    localparam logic [5:0] OP_LMW  = 6'd46;
    localparam logic [5:0] OP_STMW = 6'd47;
    localparam logic [5:0] OP_LWZ  = 6'd32;
    localparam logic [5:0] OP_STW  = 6'd36;

    // Highest GPR index; a multiple-word sequence always ends here
    localparam logic [4:0] LAST_REG = 5'd31;

    // Largest positive 16-bit displacement
    localparam logic signed [17:0] D_MAX = 18'sd32767;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_e;

    // Assemble a D-form word from its fields
    function automatic logic [0:INSTR_W-1] build_word(
        input logic [5:0]  opcd,
        input logic [4:0]  rt,
        input logic [4:0]  ra,
        input logic [15:0] d
    );
        build_word = {opcd, rt, ra, d};
    endfunction

    // Per-word displacement D + 4k, formed in 17-bit signed and truncated
    // back to 16 bits. Only legal forms use this, so nothing is lost.
    function automatic logic [15:0] word_disp(
        input logic [15:0] d,
        input logic [4:0]  k
    );
        logic signed [16:0] sum;
        sum = {d[15], d} + {10'd0, k, 2'b00};
        return sum[15:0];
    endfunction

endpackage

// File: rtl/mw_form_check.sv
// Combinational classifier for LMW/STMW: flags multiple-word opcodes and
// decides whether a given form can be split into single-word accesses.
// With STMW_EXPAND_EN undefined only LMW is ever reported expandable.
module mw_form_check
    import mw_expander_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [4:0]  rt,
    input  logic [4:0]  ra,
    input  logic [15:0] d,
    output logic        is_mw,
    output logic        expandable
);

    logic               is_lmw;
    logic               is_stmw;
    logic               base_clobber;
    logic [4:0]         span;
    logic signed [17:0] reach;
    logic               disp_ok;

    assign is_lmw  = (opcode == OP_LMW);
    assign is_stmw = (opcode == OP_STMW);
    assign is_mw   = is_lmw || is_stmw;

    // A load sequence would overwrite its own base register part way through
    assign base_clobber = (ra != 5'd0) && (ra >= rt);

    // Displacement of the final word: D + 4*(31-RT) must fit in 16 bits
    assign span    = LAST_REG - rt;
    assign reach   = {{2{d[15]}}, d} + {11'd0, span, 2'b00};
    assign disp_ok = (reach <= D_MAX);

    // Expandability decision for the supported opcodes
    always_comb begin
        expandable = 1'b0;
`ifdef STMW_EXPAND_EN
        if (is_lmw) begin
            expandable = disp_ok && !base_clobber;
        end else if (is_stmw) begin
            expandable = disp_ok;
        end
`else
        if (is_lmw) begin
            expandable = disp_ok && !base_clobber;
        end
`endif
    end

endmodule

// File: rtl/mw_expander.sv
// Load/store-multiple expander between fetch and decode. LMW (and STMW when
// STMW_EXPAND_EN is defined) is turned into one LWZ/STW per register RT..31;
// everything else passes through a single output register. Illegal
// multiple-word forms pass verbatim flagged with out_raw for a later trap.
// Optional feature macro: STMW_EXPAND_EN.
module mw_expander
    import mw_expander_pkg::*;
#(
    parameter int INSTR_WIDTH = 32
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [0:INSTR_WIDTH-1] in_instr,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [0:INSTR_WIDTH-1] out_instr,
    output logic                   out_last,
    output logic                   out_raw,
    input  logic                   out_ready,
    output logic                   busy
);

    // FSM and expansion context
    state_e                 state_q, state_d;
    logic [4:0]             cur_reg_q, cur_reg_d;
    logic [4:0]             rt_q, rt_d;
    logic [4:0]             ra_q, ra_d;
    logic [15:0]            d_q, d_d;
`ifdef STMW_EXPAND_EN
    logic                   store_q, store_d;
`endif

    // Output register
    logic                   out_valid_q, out_valid_d;
    logic [0:INSTR_WIDTH-1] out_instr_q, out_instr_d;
    logic                   out_last_q, out_last_d;
    logic                   out_raw_q, out_raw_d;

    // Decoded fields of the incoming word
    logic [5:0]             in_opcd;
    logic [4:0]             in_rt;
    logic [4:0]             in_ra;
    logic [15:0]            in_d;
    logic                   in_is_mw;
    logic                   in_expandable;

    logic                   load_en;
    logic                   accept;
    logic                   start_expand;
    logic [5:0]             in_new_op;
    logic [5:0]             seq_op;

    assign in_opcd = in_instr[OPCD_HI:OPCD_LO];
    assign in_rt   = in_instr[RT_HI:RT_LO];
    assign in_ra   = in_instr[RA_HI:RA_LO];
    assign in_d    = in_instr[D_HI:D_LO];

    mw_form_check u_form_check (
        .opcode     (in_opcd),
        .rt         (in_rt),
        .ra         (in_ra),
        .d          (in_d),
        .is_mw      (in_is_mw),
        .expandable (in_expandable)
    );

    // The output register may take a new word when empty or being drained
    assign load_en      = !out_valid_q || out_ready;
    assign accept       = in_valid && in_ready;
    assign start_expand = in_is_mw && in_expandable;

    // Single-word opcode for the first word (incoming) and later words (latched)
`ifdef STMW_EXPAND_EN
    assign in_new_op = (in_opcd == OP_STMW) ? OP_STW : OP_LWZ;
    assign seq_op    = store_q ? OP_STW : OP_LWZ;
`else
    assign in_new_op = OP_LWZ;
    assign seq_op    = OP_LWZ;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: enter EXPAND for multi-word starts, leave after reg 31
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && start_expand && (in_rt != LAST_REG)) begin
                        state_d = ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    if (load_en && (cur_reg_q == LAST_REG)) begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
    end

    // FSM outputs: accept only in IDLE with room in the output register
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            ST_IDLE:   in_ready = load_en && !flush;
            ST_EXPAND: busy     = 1'b1;
        endcase
    end

    // Datapath next values: output register contents and latched base fields
    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_last_d  = out_last_q;
        out_raw_d   = out_raw_q;
        cur_reg_d   = cur_reg_q;
        rt_d        = rt_q;
        ra_d        = ra_q;
        d_d         = d_q;
`ifdef STMW_EXPAND_EN
        store_d     = store_q;
`endif
        if (flush) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_raw_d   = 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (accept) begin
                out_valid_d = 1'b1;
                if (start_expand) begin
                    // Word 0 uses RT and the original displacement
                    out_instr_d = build_word(in_new_op, in_rt, in_ra, in_d);
                    out_last_d  = (in_rt == LAST_REG);
                    out_raw_d   = 1'b0;
                    cur_reg_d   = in_rt + 5'd1;
                    rt_d        = in_rt;
                    ra_d        = in_ra;
                    d_d         = in_d;
`ifdef STMW_EXPAND_EN
                    store_d     = (in_opcd == OP_STMW);
`endif
                end else begin
                    out_instr_d = in_instr;
                    out_last_d  = 1'b1;
                    out_raw_d   = in_is_mw;
                end
            end else if (load_en) begin
                out_valid_d = 1'b0;
            end
        end else begin
            // EXPAND: the register always holds a word here, so advance on consume
            if (load_en) begin
                out_valid_d = 1'b1;
                out_instr_d = build_word(seq_op, cur_reg_q, ra_q,
                                         word_disp(d_q, cur_reg_q - rt_q));
                out_last_d  = (cur_reg_q == LAST_REG);
                out_raw_d   = 1'b0;
                cur_reg_d   = cur_reg_q + 5'd1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_last_q  <= 1'b0;
            out_raw_q   <= 1'b0;
            cur_reg_q   <= 5'd0;
            rt_q        <= 5'd0;
            ra_q        <= 5'd0;
            d_q         <= 16'd0;
`ifdef STMW_EXPAND_EN
            store_q     <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_last_q  <= out_last_d;
            out_raw_q   <= out_raw_d;
            cur_reg_q   <= cur_reg_d;
            rt_q        <= rt_d;
            ra_q        <= ra_d;
            d_q         <= d_d;
`ifdef STMW_EXPAND_EN
            store_q     <= store_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_last  = out_last_q;
    assign out_raw   = out_raw_q;

endmodule

// File: tb/tb_mw_expander.sv
// Testbench for mw_expander: directed test-plan sequences plus randomized
// traffic, checked by a scoreboard queue popped by an output monitor.
`timescale 1ns/1ps
module tb_mw_expander;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [0:31] in_instr = '0;
    logic        in_ready;
    logic        out_valid;
    logic [0:31] out_instr;
    logic        out_last;
    logic        out_raw;
    logic        out_ready = 1'b0;
    logic        busy;

`ifdef STMW_EXPAND_EN
    localparam bit STMW_EN = 1'b1;
`else
    localparam bit STMW_EN = 1'b0;
`endif

    mw_expander #(.INSTR_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_last  (out_last),
        .out_raw   (out_raw),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] instr;
        logic        last;
        logic        raw;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] w, input logic last, input logic raw);
        exp_t e;
        e.instr = w;
        e.last  = last;
        e.raw   = raw;
        exp_q.push_back(e);
    endtask

    // Reference model: what an accepted instruction must turn into
    task automatic model(input logic [0:31] ins);
        int opcd, rt, ra, d;
        bit ok;
        opcd = int'(ins[0:5]);
        rt   = int'(ins[6:10]);
        ra   = int'(ins[11:15]);
        d    = int'($signed(ins[16:31]));
        if (opcd == 46 || opcd == 47) begin
            ok = (opcd == 46 || STMW_EN)
                 && !(opcd == 46 && ra != 0 && ra >= rt)
                 && (d + 4 * (31 - rt) <= 32767);
            if (ok) begin
                for (int r = rt; r <= 31; r++) begin
                    push({(opcd == 46) ? 6'd32 : 6'd36, 5'(r), 5'(ra), 16'(d + 4 * (r - rt))},
                         r == 31, 1'b0);
                end
            end else begin
                push(ins, 1'b1, 1'b1);
            end
        end else begin
            push(ins, 1'b1, 1'b0);
        end
    endtask

    // Output ready driver: forced level or random backpressure
    bit rand_ready  = 1'b0;
    bit ready_force = 1'b1;
    always @(posedge clk) begin
        #2;
        out_ready = rand_ready ? ($urandom_range(0, 9) < 7) : ready_force;
    end

    // Monitor: pop and compare on every transfer, check stability under stall
    bit          mon_en = 1'b0;
    bit          prev_stall = 1'b0;
    logic [33:0] prev_out;
    int          prev_xfer = -10;
    int          last_xfer = -10;
    exp_t        mon_e;
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (prev_stall) begin
                chk("hold_stable", {out_valid, out_instr, out_last, out_raw}, {1'b1, prev_out});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got %0h, required no output", out_instr);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_word", {out_instr, out_last, out_raw}, {mon_e.instr, mon_e.last, mon_e.raw});
                end
                prev_xfer = last_xfer;
                last_xfer = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_instr, out_last, out_raw};
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Present one instruction until accepted (bounded)
    task automatic send(input logic [0:31] ins, input bit use_model);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_instr = ins;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                if (use_model) model(ins);
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: instr %0h not accepted, required acceptance", ins);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic logic [0:31] rand_instr();
        logic [0:31] w;
        int sel, rt, ra, d;
        sel = int'($urandom_range(0, 9));
        w   = $urandom;
        if (sel < 7) begin
            rt = ($urandom_range(0, 1) == 1) ? int'($urandom_range(22, 31)) : int'($urandom_range(0, 31));
            ra = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0: d = int'($urandom_range(0, 400)) - 200;
                1: d = 32767 - 4 * (31 - rt) + int'($urandom_range(0, 2)) - 1;
                2: d = int'($urandom_range(0, 65535)) - 32768;
                default: d = int'($urandom_range(0, 64)) * 4;
            endcase
            w = {(sel < 4) ? 6'd46 : 6'd47, 5'(rt), 5'(ra), 16'(d)};
        end else begin
            while (w[0:5] == 6'd46 || w[0:5] == 6'd47) w[0:5] = 6'($urandom_range(0, 63));
        end
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_raw", out_raw, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // LMW r29,8(r1): three words, in_ready low for two cycles
        push(32'h83A10008, 1'b0, 1'b0);
        push(32'h83C1000C, 1'b0, 1'b0);
        push(32'h83E10010, 1'b1, 1'b0);
        send(32'hBBA10008, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lmw29_in_ready", in_ready, (i == 2));
            chk("lmw29_busy", busy, (i != 2));
        end
        drain();
        chk("lmw29_no_gap", last_xfer - prev_xfer, 1);

        // STMW r30,-8(r1)
        if (STMW_EN) begin
            push(32'h93C1FFF8, 1'b0, 1'b0);
            push(32'h93E1FFFC, 1'b1, 1'b0);
        end else begin
            push(32'hBFC1FFF8, 1'b1, 1'b1);
        end
        send(32'hBFC1FFF8, 1'b0);
        drain();

        // ADDI then LMW r31,0(r1), back to back
        push(32'h38600001, 1'b1, 1'b0);
        push(32'h83E10000, 1'b1, 1'b0);
        send(32'h38600001, 1'b0);
        send(32'hBBE10000, 1'b0);
        drain();
        chk("b2b_no_bubble", last_xfer - prev_xfer, 1);

        // Illegal forms pass raw
        push(32'hBB9E0000, 1'b1, 1'b1);
        push(32'hB8017FF0, 1'b1, 1'b1);
        send(32'hBB9E0000, 1'b0);
        send(32'hB8017FF0, 1'b0);
        drain();

        // Backpressure on word 2 for three cycles
        push(32'h83A10008, 1'b0, 1'b0);
        push(32'h83C1000C, 1'b0, 1'b0);
        push(32'h83E10010, 1'b1, 1'b0);
        send(32'hBBA10008, 1'b0);
        @(posedge clk);
        #1;
        ready_force = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_word", {out_valid, out_instr}, {1'b1, 32'h83C1000C});
            chk("bp_busy", busy, 1);
        end
        ready_force = 1'b1;
        drain();

        // Flush mid-sequence
        push(32'h83A10008, 1'b0, 1'b0);
        send(32'hBBA10008, 1'b0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_busy", busy, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_last_raw", {out_last, out_raw}, 0);
        repeat (2) @(posedge clk);
        #1;

        // Flush wins over a simultaneous offer
        in_valid = 1'b1;
        in_instr = 32'h38600001;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_prio_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_prio_out_valid", out_valid, 0);
        @(posedge clk);
        #1;

        // Reset mid-sequence
        push(32'h83A10008, 1'b0, 1'b0);
        send(32'hBBA10008, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("midrst_outputs", {out_valid, out_instr, out_last, out_raw, busy}, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic with random backpressure
        rand_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            int gap;
            send(rand_instr(), 1'b1);
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(posedge clk);
            if (gap > 0) #1;
        end
        drain();
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
